priority_ni_fifo_rdctrl: RTL and testbench
==========================================

PRIORITY_NI_FIFO_RDCTRL -- requirements
Module: priority_ni_fifo_rdctrl

Interface
REQ-001 SHALL have parameter TAIL_TIMEOUT, default 8'd255, max cycles waited in TAIL_WAIT for a tail flit.
REQ-002 SHALL have port clk  input  1  single clock; all flops rising-edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port priorityNI_FIFO_empty  input  1  priority FIFO empty flag.
REQ-005 SHALL have port priorityFIFO_q  input  16  FIFO read data, valid one cycle after rd.
REQ-006 SHALL have port priorityNI_FIFO_rd  output  1  FIFO pop strobe.
REQ-007 SHALL have port irq_valid  output  1  decoded interrupt available to local core.
REQ-008 SHALL have port irq_src  output  4  source core_address of the interrupt.
REQ-009 SHALL have port irq_num  output  4  interrupt vector index, 0..15.
REQ-010 SHALL have port irq_ack  input  1  core accepts the presented interrupt.
REQ-011 SHALL have port err_cnt  output  8  saturating protocol-error count.

Function
REQ-012 SHALL decode head flit as q[15:13]=3'b001, q[7:4]=source address, q[3:0]=vector index; bits q[12:8] are ignored.
REQ-013 SHALL decode tail flit as q[15:13]=3'b110; remaining bits are ignored.
REQ-014 SHALL implement states IDLE, HEAD_CHK, TAIL_WAIT, TAIL_CHK, DELIVER.
REQ-015 IDLE: when empty=0, SHALL assert rd for one cycle and go to HEAD_CHK; otherwise stay.
REQ-016 HEAD_CHK: on head type, SHALL latch src/num and go to TAIL_WAIT; on any other type, SHALL increment err_cnt and go to IDLE.
REQ-017 TAIL_WAIT: when empty=0, SHALL assert rd, clear the timeout counter, and go to TAIL_CHK; otherwise increment the timeout counter.
REQ-018 TAIL_WAIT: when the timeout counter reaches TAIL_TIMEOUT with the FIFO still empty, SHALL increment err_cnt, drop the packet, and go to IDLE.
REQ-019 TAIL_CHK: on tail type, SHALL go to DELIVER.
REQ-020 TAIL_CHK: on head type (lost tail), SHALL increment err_cnt, relatch src/num from the new head, and go to TAIL_WAIT.
REQ-021 TAIL_CHK: on any other type, SHALL increment err_cnt and go to IDLE.
REQ-022 DELIVER: SHALL drive irq_valid=1 with src/num held stable until a cycle with irq_ack=1, then go to IDLE with irq_valid=0 next cycle.
REQ-023 irq_ack outside DELIVER SHALL be ignored.
REQ-024 rd SHALL never assert while empty=1, and SHALL never assert in HEAD_CHK, TAIL_CHK or DELIVER.
REQ-025 Minimum latency SHALL be 4 cycles from first rd to irq_valid=1, with both flits present and no stalls.
REQ-026 err_cnt SHALL saturate at 8'hFF.
REQ-027 Back-to-back packets: the next head rd SHALL be issued at the earliest in the cycle after leaving DELIVER.

Reset
REQ-028 rst_n=0 SHALL immediately force: state IDLE, rd=0, irq_valid=0, irq_src=0, irq_num=0, err_cnt=0, timeout counter=0.
REQ-029 Reset mid-packet SHALL discard the partial packet; flits left in the FIFO are decoded afresh after release.

Structure
REQ-030 Flit type codes (HEAD 3'b001, TAIL 3'b110), the field bit positions, and the state encoding SHALL live in a shared package also used by the write controller.
REQ-031 The saturating error counter SHALL be one sub-module, sat_cnt8.

Verification
REQ-032 FIFO holds 16'h2035 then 16'hC000 -> irq_valid=1, irq_src=3, irq_num=5 four cycles after first rd; holds until irq_ack, err_cnt=0.
REQ-033 Head 16'h20A7, FIFO empty for 255 cycles -> err_cnt=1, state IDLE, irq_valid never asserted.
REQ-034 16'h2012, 16'h2034, 16'hC000 -> err_cnt=1, irq_src=3, irq_num=4.
REQ-035 Stray 16'hC000 alone -> err_cnt=1, no irq_valid, one rd only.
REQ-036 rst_n low while in TAIL_WAIT -> all outputs 0 asynchronously; next complete packet is delivered correctly.
REQ-037 300 malformed flits -> err_cnt=8'hFF, no wrap to 0; rd=0 in every cycle with empty=1.

Source files
------------

// File: rtl/priority_ni_fifo_rdctrl_pkg.sv
// Flit format and read-controller state encoding for the priority NI FIFO path.
// The write controller imports this package too, so both sides agree on flit layout.
package priority_ni_fifo_rdctrl_pkg;

  localparam int unsigned FLIT_W   = 16;
  localparam int unsigned TYPE_W   = 3;
  localparam int unsigned SRC_W    = 4;
  localparam int unsigned NUM_W    = 4;
  localparam int unsigned ERR_W    = 8;
  localparam int unsigned TMO_W    = 8;

  localparam int unsigned TYPE_MSB = 15;
  localparam int unsigned TYPE_LSB = 13;
  localparam int unsigned SRC_MSB  = 7;
  localparam int unsigned SRC_LSB  = 4;
  localparam int unsigned NUM_MSB  = 3;
  localparam int unsigned NUM_LSB  = 0;

  typedef logic [FLIT_W-1:0] flit_t;
  typedef logic [TYPE_W-1:0] flit_type_t;

  localparam flit_type_t FLIT_HEAD = 3'b001;
  localparam flit_type_t FLIT_TAIL = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HEAD_CHK  = 3'd1,
    ST_TAIL_WAIT = 3'd2,
    ST_TAIL_CHK  = 3'd3,
    ST_DELIVER   = 3'd4
  } rd_state_e;

  typedef struct packed {
    logic [SRC_W-1:0] src;
    logic [NUM_W-1:0] num;
  } irq_info_t;

  function automatic flit_type_t flit_type(input flit_t flit);
    return flit[TYPE_MSB:TYPE_LSB];
  endfunction

  function automatic irq_info_t head_info(input flit_t flit);
    irq_info_t info;
    info.src = flit[SRC_MSB:SRC_LSB];
    info.num = flit[NUM_MSB:NUM_LSB];
    return info;
  endfunction

  // Builders for the write side; unused header bits are sent as zero.
  function automatic flit_t make_head(input logic [SRC_W-1:0] src,
                                      input logic [NUM_W-1:0] num);
    return {FLIT_HEAD, 5'd0, src, num};
  endfunction

  function automatic flit_t make_tail();
    return {FLIT_TAIL, 13'd0};
  endfunction

endpackage

// File: rtl/priority_ni_fifo_rdctrl_if.sv
// FIFO read port plus interrupt delivery port of the priority NI read controller.
interface priority_ni_fifo_rdctrl_if;
  import priority_ni_fifo_rdctrl_pkg::*;

  logic                 priorityNI_FIFO_empty;
  logic [FLIT_W-1:0]    priorityFIFO_q;
  logic                 priorityNI_FIFO_rd;
  logic                 irq_valid;
  logic [SRC_W-1:0]     irq_src;
  logic [NUM_W-1:0]     irq_num;
  logic                 irq_ack;
  logic [ERR_W-1:0]     err_cnt;

  // master: the read controller; slave: the FIFO and local core it talks to
  modport master (
    input  priorityNI_FIFO_empty, priorityFIFO_q, irq_ack,
    output priorityNI_FIFO_rd, irq_valid, irq_src, irq_num, err_cnt
  );

  modport slave (
    output priorityNI_FIFO_empty, priorityFIFO_q, irq_ack,
    input  priorityNI_FIFO_rd, irq_valid, irq_src, irq_num, err_cnt
  );

endinterface

// File: rtl/priority_ni_fifo_rdctrl_sat_cnt8.sv
// 8-bit event counter that sticks at all-ones instead of wrapping.
module sat_cnt8
  import priority_ni_fifo_rdctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [ERR_W-1:0] cnt_o
);

  logic [ERR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/priority_ni_fifo_rdctrl.sv
// Pops head/tail flit pairs from the priority NI FIFO and presents each
// well-formed packet to the local core as an interrupt with src/vector.
module priority_ni_fifo_rdctrl
  import priority_ni_fifo_rdctrl_pkg::*;
#(
  parameter logic [TMO_W-1:0] TAIL_TIMEOUT = 8'd255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  priority_ni_fifo_rdctrl_if.master   bus
);

  rd_state_e        state_q, state_d;
  irq_info_t        info_q, info_d;
  logic [TMO_W-1:0] tmo_q, tmo_d, tmo_inc;
  logic             rd;
  logic             err_inc;
  flit_type_t       ftype;

  assign ftype   = flit_type(bus.priorityFIFO_q);
  assign tmo_inc = tmo_q + 1'b1;

  always_comb begin
    state_d = state_q;
    info_d  = info_q;
    tmo_d   = '0;
    rd      = 1'b0;
    err_inc = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!bus.priorityNI_FIFO_empty) begin
          rd      = 1'b1;
          state_d = ST_HEAD_CHK;
        end
      end
      ST_HEAD_CHK: begin
        if (ftype == FLIT_HEAD) begin
          info_d  = head_info(bus.priorityFIFO_q);
          state_d = ST_TAIL_WAIT;
        end else begin
          err_inc = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_TAIL_WAIT: begin
        // The timeout fires on the empty cycle that brings the count to
        // TAIL_TIMEOUT, so at most TAIL_TIMEOUT empty cycles are waited.
        if (!bus.priorityNI_FIFO_empty) begin
          rd      = 1'b1;
          state_d = ST_TAIL_CHK;
        end else if (tmo_inc == TAIL_TIMEOUT) begin
          err_inc = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d   = tmo_inc;
        end
      end
      ST_TAIL_CHK: begin
        if (ftype == FLIT_TAIL) begin
          state_d = ST_DELIVER;
        end else if (ftype == FLIT_HEAD) begin
          err_inc = 1'b1;
          info_d  = head_info(bus.priorityFIFO_q);
          state_d = ST_TAIL_WAIT;
        end else begin
          err_inc = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DELIVER: begin
        if (bus.irq_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      info_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      info_q  <= info_d;
      tmo_q   <= tmo_d;
    end
  end

  sat_cnt8 u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (err_inc),
    .cnt_o (bus.err_cnt)
  );

  // The pop strobe is decoded from IDLE, which is also the reset state;
  // masking with rst_n keeps it low while reset holds a non-empty FIFO.
  assign bus.priorityNI_FIFO_rd = rd & rst_n;
  assign bus.irq_valid          = (state_q == ST_DELIVER);
  assign bus.irq_src            = info_q.src;
  assign bus.irq_num            = info_q.num;

  a_rd_not_empty: assert property (@(posedge clk) disable iff (!rst_n)
    bus.priorityNI_FIFO_rd |-> !bus.priorityNI_FIFO_empty);

  a_irq_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.irq_valid && !bus.irq_ack) |=>
      (bus.irq_valid && $stable(bus.irq_src) && $stable(bus.irq_num)));

endmodule

// File: tb/tb_priority_ni_fifo_rdctrl.sv
// Scoreboard bench for priority_ni_fifo_rdctrl: a flit FIFO model feeds the DUT
// and a core model checks each delivered interrupt against queued expectations.
module tb_priority_ni_fifo_rdctrl;

  typedef struct packed {
    logic [3:0] src;
    logic [3:0] num;
  } exp_irq_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  priority_ni_fifo_rdctrl_if bus ();

  priority_ni_fifo_rdctrl #(.TAIL_TIMEOUT(8'd255)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;

  logic [15:0] fifo_mem [$];
  int unsigned rd_ptr   = 0;
  int unsigned wr_ptr   = 0;

  exp_irq_t    exp_q [$];
  exp_irq_t    cur_exp;
  int unsigned exp_irqs = 0;
  int          exp_err  = 0;

  int unsigned rd_total = 0;
  int unsigned rd_viol  = 0;
  int unsigned irq_starts = 0;
  int unsigned irq_done   = 0;
  int unsigned irq_first_cyc = 0;
  int unsigned last_ack_cyc  = 0;
  int unsigned irq_gap       = 0;
  int unsigned held          = 0;
  int unsigned ack_delay     = 2;
  logic        force_ack     = 1'b0;
  logic        in_irq        = 1'b0;
  logic        ack_pending   = 1'b0;

  logic [2:0] bad_types [6] = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b101, 3'b111};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] f);
    fifo_mem.push_back(f);
    wr_ptr++;
  endtask

  task automatic sb_expect(input logic [3:0] s, input logic [3:0] v);
    exp_irq_t e;
    e.src = s;
    e.num = v;
    exp_q.push_back(e);
    exp_irqs++;
  endtask

  task automatic bump_err(input int n);
    exp_err = (exp_err + n > 255) ? 255 : exp_err + n;
  endtask

  task automatic wait_irqs(input int unsigned target, input int unsigned budget);
    int unsigned n = 0;
    while (irq_done < target && n < budget) begin
      step(1);
      n++;
    end
    check_eq("irq_done", irq_done, target);
  endtask

  // FIFO model: data appears on q the cycle after the pop strobe
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.priorityNI_FIFO_rd && (rd_ptr < wr_ptr)) begin
      bus.priorityFIFO_q <= fifo_mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end
  assign bus.priorityNI_FIFO_empty = (rd_ptr == wr_ptr);

  always @(negedge clk) begin : rd_monitor
    if (bus.priorityNI_FIFO_rd) rd_total++;
    if (bus.priorityNI_FIFO_rd && (bus.priorityNI_FIFO_empty || !rst_n)) rd_viol++;
  end

  // Core model: checks each presented interrupt every held cycle, then acks
  always @(negedge clk) begin : responder
    logic ack_now;
    ack_now = 1'b0;
    if (!rst_n) begin
      in_irq      = 1'b0;
      ack_pending = 1'b0;
    end else if (ack_pending) begin
      check_eq("irq_drop_after_ack", bus.irq_valid, 1'b0);
      ack_pending = 1'b0;
      in_irq      = 1'b0;
      irq_done++;
    end else if (bus.irq_valid) begin
      if (!in_irq) begin
        in_irq        = 1'b1;
        held          = 0;
        irq_starts++;
        irq_first_cyc = cyc;
        irq_gap       = cyc - last_ack_cyc;
        check_eq("sb_nonempty", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) cur_exp = exp_q.pop_front();
        else                  cur_exp = '0;
      end else begin
        held++;
      end
      check_eq("irq_src", bus.irq_src, cur_exp.src);
      check_eq("irq_num", bus.irq_num, cur_exp.num);
      if (force_ack || held >= ack_delay) begin
        ack_now      = 1'b1;
        ack_pending  = 1'b1;
        last_ack_cyc = cyc;
      end
    end
    bus.irq_ack = ack_now | force_ack;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached after %0d checks", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned c0, r0, n;

    step(3);
    check_eq("rst_rd",        bus.priorityNI_FIFO_rd, 0);
    check_eq("rst_irq_valid", bus.irq_valid, 0);
    check_eq("rst_irq_src",   bus.irq_src, 0);
    check_eq("rst_irq_num",   bus.irq_num, 0);
    check_eq("rst_err_cnt",   bus.err_cnt, 0);
    rst_n = 1'b1;
    step(2);

    // Clean packet: 4-cycle latency, held three extra cycles before ack
    ack_delay = 3;
    push(16'h2035); push(16'hC000); sb_expect(4'h3, 4'h5);
    c0 = cyc;
    wait_irqs(exp_irqs, 40);
    check_eq("latency", irq_first_cyc - c0, 4);
    check_eq("err_clean", bus.err_cnt, exp_err);
    step(1);

    // Lost tail: second head replaces the first
    ack_delay = 1;
    push(16'h2012); push(16'h2034); push(16'hC000); sb_expect(4'h3, 4'h4);
    bump_err(1);
    wait_irqs(exp_irqs, 60);
    check_eq("err_lost_tail", bus.err_cnt, exp_err);
    step(1);

    // Stray tail alone
    r0 = rd_total;
    push(16'hC000);
    bump_err(1);
    step(6);
    check_eq("err_stray", bus.err_cnt, exp_err);
    check_eq("rd_stray", rd_total - r0, 1);
    check_eq("irq_stray", irq_starts, exp_irqs);

    // Tail never arrives
    push(16'h20A7);
    bump_err(1);
    step(300);
    check_eq("err_timeout", bus.err_cnt, exp_err);
    check_eq("irq_timeout", irq_starts, exp_irqs);

    // Tail after 254 empty waiting cycles still accepted
    push(16'h20B8);
    step(256);
    push(16'hC000); sb_expect(4'hB, 4'h8);
    wait_irqs(exp_irqs, 40);
    check_eq("err_tmo_edge_ok", bus.err_cnt, exp_err);
    step(2);

    // One more empty cycle times out; late tail is then a stray
    push(16'h20C9);
    step(257);
    push(16'hC000);
    bump_err(2);
    step(10);
    check_eq("err_tmo_edge_drop", bus.err_cnt, exp_err);
    check_eq("irq_tmo_edge_drop", irq_starts, exp_irqs);

    // Back-to-back packets, ignored header/tail bits set on the second
    ack_delay = 0;
    push(16'h2041); push(16'hC000); sb_expect(4'h4, 4'h1);
    push(16'h3F52); push(16'hDABC); sb_expect(4'h5, 4'h2);
    wait_irqs(exp_irqs, 80);
    check_eq("b2b_gap", irq_gap, 5);
    check_eq("err_b2b", bus.err_cnt, exp_err);
    step(1);

    // ack held high outside DELIVER is ignored; packet shown for one cycle
    force_ack = 1'b1;
    push(16'h2063); push(16'hC000); sb_expect(4'h6, 4'h3);
    wait_irqs(exp_irqs, 40);
    force_ack = 1'b0;
    check_eq("err_force_ack", bus.err_cnt, exp_err);
    step(2);

    // Reset while waiting for a tail
    push(16'h2019);
    step(5);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_rd",        bus.priorityNI_FIFO_rd, 0);
    check_eq("arst_irq_valid", bus.irq_valid, 0);
    check_eq("arst_irq_src",   bus.irq_src, 0);
    check_eq("arst_irq_num",   bus.irq_num, 0);
    check_eq("arst_err_cnt",   bus.err_cnt, 0);
    exp_err = 0;
    push(16'h20A6); push(16'hDABC);
    step(3);
    check_eq("arst_rd_held", bus.priorityNI_FIFO_rd, 0);
    rst_n = 1'b1;
    sb_expect(4'hA, 4'h6);
    wait_irqs(exp_irqs, 40);
    check_eq("err_after_rst", bus.err_cnt, exp_err);
    step(2);

    // Saturation: 300 malformed heads with random idle gaps
    for (int i = 0; i < 300; i++) begin
      push({bad_types[$urandom_range(0, 5)], 13'($urandom)});
      if ($urandom_range(0, 3) == 0) step($urandom_range(1, 3));
    end
    n = 0;
    while (!bus.priorityNI_FIFO_empty && n < 2000) begin
      step(1);
      n++;
    end
    check_eq("sat_drain", bus.priorityNI_FIFO_empty, 1);
    step(4);
    bump_err(300);
    check_eq("err_saturated", bus.err_cnt, exp_err);
    check_eq("irq_sat", irq_starts, exp_irqs);

    check_eq("rd_while_empty", rd_viol, 0);
    check_eq("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
